// File: rtl/apb2_mult_sequencer_pkg.sv
// Shared types and constants for the APB2 multiplier sequencer.
package apb2_mult_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_MER,
        WR_MCD,
        WR_CMD,
        RD_STAT,
        RD_RES,
        OUT
    } seq_state_t;

    localparam logic [9:0]  ADDR_MER      = 10'h00;
    localparam logic [9:0]  ADDR_MCD      = 10'h01;
    localparam logic [9:0]  ADDR_CMD      = 10'h02;
    localparam logic [9:0]  ADDR_RES      = 10'h03;
    localparam logic [31:0] CMD_START     = 32'h1;
    localparam int          STAT_DONE_BIT = 1;

    function automatic logic is_xfer(input seq_state_t s);
        return (s == WR_MER) || (s == WR_MCD) || (s == WR_CMD) ||
               (s == RD_STAT) || (s == RD_RES);
    endfunction

endpackage

// File: rtl/apb2_mult_sequencer_xfer.sv
// Single APB2 transfer engine: setup cycle then access cycle, no PREADY.
module apb2_xfer (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        req,
    input  logic        write,
    input  logic [9:0]  addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [9:0]  paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata
);

    // done marks the access cycle; a req seen then starts the next setup back-to-back
    assign done  = psel & penable;
    assign rdata = prdata;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
        end else if (req && (!psel || penable)) begin
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= write;
            paddr   <= addr;
            if (write) pwdata <= wdata;
        end else if (psel && !penable) begin
            penable <= 1'b1;
        end else begin
            psel    <= 1'b0;
            penable <= 1'b0;
        end
    end

endmodule

// File: rtl/apb2_mult_sequencer.sv
// Valid/ready to APB2 sequencer for the multiplier peripheral.
// Optional poll timeout enabled by defining MULT_SEQ_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for an operand pair (op_ready=1)
// WR_MER  | writing sign-extended op_a to the multiplier register
// WR_MCD  | writing sign-extended op_b to the multiplicand register
// WR_CMD  | writing the start command
// RD_STAT | polling the done bit
// RD_RES  | reading the product
// OUT     | presenting the product until res_ready
module apb2_mult_sequencer
    import apb2_mult_sequencer_pkg::*;
#(
    parameter int POLL_LIMIT = 255
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_err,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [9:0]  paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata
);

    seq_state_t  state, next_state;
    logic [7:0]  op_a_q, op_b_q, mer_src;
    logic        xfer_req, xfer_write, xfer_done, poll_timeout;
    logic [9:0]  xfer_addr;
    logic [31:0] xfer_wdata, xfer_rdata;
    logic        unused_rdata;

    assign unused_rdata = ^xfer_rdata[31:16];
    // The multiplier write launches on the accept edge, before op_a_q is loaded
    assign mer_src = (state == IDLE) ? op_a : op_a_q;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (op_valid)  next_state = WR_MER;
            WR_MER:  if (xfer_done) next_state = WR_MCD;
            WR_MCD:  if (xfer_done) next_state = WR_CMD;
            WR_CMD:  if (xfer_done) next_state = RD_STAT;
            RD_STAT: if (xfer_done) begin
                if (xfer_rdata[STAT_DONE_BIT]) next_state = RD_RES;
                else if (poll_timeout)         next_state = OUT;
            end
            RD_RES:  if (xfer_done) next_state = OUT;
            OUT:     if (res_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        xfer_req   = is_xfer(next_state) && (xfer_done || state == IDLE);
        xfer_write = 1'b1;
        xfer_addr  = ADDR_MER;
        xfer_wdata = {{24{mer_src[7]}}, mer_src};
        case (next_state)
            WR_MCD: begin
                xfer_addr  = ADDR_MCD;
                xfer_wdata = {{24{op_b_q[7]}}, op_b_q};
            end
            WR_CMD: begin
                xfer_addr  = ADDR_CMD;
                xfer_wdata = CMD_START;
            end
            RD_STAT: begin
                xfer_write = 1'b0;
                xfer_addr  = ADDR_CMD;
            end
            RD_RES: begin
                xfer_write = 1'b0;
                xfer_addr  = ADDR_RES;
            end
            default: ;
        endcase
    end

    apb2_xfer u_xfer (
        .pclk    (pclk),
        .presetn (presetn),
        .req     (xfer_req),
        .write   (xfer_write),
        .addr    (xfer_addr),
        .wdata   (xfer_wdata),
        .done    (xfer_done),
        .rdata   (xfer_rdata),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= IDLE;
            op_ready  <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
        end else begin
            state     <= next_state;
            op_ready  <= (next_state == IDLE);
            res_valid <= (next_state == OUT);
            if (state == IDLE && op_valid) begin
                op_a_q <= op_a;
                op_b_q <= op_b;
            end
            if (state == RD_RES && xfer_done)
                res_data <= xfer_rdata[15:0];
            else if (state == RD_STAT && next_state == OUT)
                res_data <= '0;
        end
    end

`ifdef MULT_SEQ_TIMEOUT_EN
    localparam logic [7:0] POLL_LIM8 = 8'(POLL_LIMIT);
    logic [7:0] poll_cnt;

    assign poll_timeout = (poll_cnt + 8'd1) == POLL_LIM8;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            poll_cnt <= '0;
            res_err  <= 1'b0;
        end else begin
            if (state == WR_MCD && next_state == WR_CMD)
                poll_cnt <= '0;
            else if (state == RD_STAT && xfer_done)
                poll_cnt <= poll_cnt + 8'd1;
            if (state == RD_STAT && next_state == OUT)
                res_err <= 1'b1;
            else if (state == OUT && res_ready)
                res_err <= 1'b0;
        end
    end
`else
    logic unused_poll_limit;
    assign unused_poll_limit = (POLL_LIMIT != 0);
    assign poll_timeout      = 1'b0;
    assign res_err           = 1'b0;
`endif

endmodule

// File: tb/tb_apb2_mult_sequencer.sv
// Directed bench: sequencer paired with a behavioural multiplier slave.
module tb_apb2_mult_sequencer;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [7:0]  op_a = '0;
    logic [7:0]  op_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_err;
    logic        psel, penable, pwrite;
    logic [9:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;

    int tests = 0;
    int fails = 0;

`ifdef MULT_SEQ_TIMEOUT_EN
    localparam int PL = 4;
`else
    localparam int PL = 255;
`endif

    apb2_mult_sequencer #(.POLL_LIMIT(PL)) dut (
        .pclk(pclk), .presetn(presetn),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    // Behavioural multiplier slave: repeated-add timing of |mer| cycles
    typedef struct { logic [9:0] addr; logic [31:0] data; } wr_t;
    wr_t wr_log[$];
    logic signed [7:0]  s_mer, s_mcd;
    logic signed [15:0] s_res;
    logic s_done, s_busy;
    int   s_cnt;
    int   stat_reads = 0;
    bit   never_done = 1'b0;

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            s_mer <= '0; s_mcd <= '0; s_res <= '0;
            s_done <= 1'b0; s_busy <= 1'b0; s_cnt <= 0;
        end else begin
            if (s_busy) begin
                if (s_cnt <= 1) begin
                    s_busy <= 1'b0;
                    s_done <= !never_done;
                    s_res  <= s_mer * s_mcd;
                end else begin
                    s_cnt <= s_cnt - 1;
                end
            end
            if (psel && !penable && pwrite) begin
                wr_log.push_back('{paddr, pwdata});
                case (paddr)
                    10'h0: s_mer <= pwdata[7:0];
                    10'h1: s_mcd <= pwdata[7:0];
                    10'h2: if (pwdata[0]) begin
                        s_done <= 1'b0;
                        s_busy <= 1'b1;
                        s_cnt  <= (s_mer < 0) ? -int'(s_mer) : int'(s_mer);
                    end
                    default: ;
                endcase
            end
            if (psel && penable && !pwrite && paddr == 10'h2)
                stat_reads <= stat_reads + 1;
        end
    end

    always_comb begin
        prdata = 32'hA5A5_A5A4;
        if (psel && penable && !pwrite) begin
            if (paddr == 10'h2)      prdata = {30'b0, s_done, 1'b0};
            else if (paddr == 10'h3) prdata = {16'h0, s_res};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_op(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        @(negedge pclk);
        op_a = a; op_b = b; op_valid = 1'b1;
        while (!op_ready && n < 300) begin
            @(negedge pclk);
            n++;
        end
        check("op_ready_wait", {31'b0, op_ready}, 32'd1);
        @(posedge pclk);
        #1 op_valid = 1'b0;
    endtask

    task automatic wait_res(output int cycles);
        cycles = 0;
        do begin
            @(negedge pclk);
            cycles++;
        end while (!res_valid && cycles < 400);
        check("res_valid_wait", {31'b0, res_valid}, 32'd1);
    endtask

    task automatic take_res();
        res_ready = 1'b1;
        @(posedge pclk);
        #1 res_ready = 1'b0;
    endtask

    initial begin
        int cyc, idx, sr, n;

        // reset state
        #12;
        check("rst_op_ready", {31'b0, op_ready}, 32'd1);
        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("rst_psel", {31'b0, psel}, 32'd0);
        check("rst_paddr", {22'b0, paddr}, 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        check("rst_res_data", {16'b0, res_data}, 32'd0);
        @(negedge pclk);
        presetn = 1'b1;

        // Scenario 1: 3*5
        idx = wr_log.size(); sr = stat_reads;
        send_op(8'd3, 8'd5);
        check("s1_op_ready_low", {31'b0, op_ready}, 32'd0);
        wait_res(cyc);
        check("s1_latency_le19", {31'b0, cyc <= 19}, 32'd1);
        check("s1_nwrites", wr_log.size() - idx, 32'd3);
        check("s1_w0_addr", {22'b0, wr_log[idx].addr}, 32'h0);
        check("s1_w0_data", wr_log[idx].data, 32'd3);
        check("s1_w1_addr", {22'b0, wr_log[idx+1].addr}, 32'h1);
        check("s1_w1_data", wr_log[idx+1].data, 32'd5);
        check("s1_w2_addr", {22'b0, wr_log[idx+2].addr}, 32'h2);
        check("s1_w2_data", wr_log[idx+2].data, 32'd1);
        check("s1_polls", stat_reads - sr, 32'd2);
        check("s1_res", {16'b0, res_data}, 32'd15);
        check("s1_err", {31'b0, res_err}, 32'd0);
        take_res();
        check("s1_valid_drop", {31'b0, res_valid}, 32'd0);

        // Scenario 2: -4*7
        idx = wr_log.size();
        send_op(8'hFC, 8'd7);
        wait_res(cyc);
        check("s2_latency", {31'b0, cyc <= 20}, 32'd1);
        check("s2_w0_data", wr_log[idx].data, 32'hFFFF_FFFC);
        check("s2_w1_data", wr_log[idx+1].data, 32'h0000_0007);
        check("s2_res", {16'b0, res_data}, 32'h0000_FFE4);
        take_res();

        // Scenario 3: 0*-128, one poll, minimum latency
        idx = wr_log.size(); sr = stat_reads;
        send_op(8'd0, 8'h80);
        wait_res(cyc);
        check("s3_latency", cyc, 32'd11);
        check("s3_polls", stat_reads - sr, 32'd1);
        check("s3_w1_data", wr_log[idx+1].data, 32'hFFFF_FF80);
        check("s3_res", {16'b0, res_data}, 32'd0);
        take_res();

        // Scenario 4: back-to-back with consumer stall
        send_op(8'd2, 8'd2);
        @(negedge pclk);
        op_a = 8'h80; op_b = 8'h80; op_valid = 1'b1;
        wait_res(cyc);
        for (int i = 0; i < 5; i++) begin
            check("s4_hold_data", {16'b0, res_data}, 32'd4);
            check("s4_hold_ready", {31'b0, op_ready}, 32'd0);
            check("s4_hold_valid", {31'b0, res_valid}, 32'd1);
            @(negedge pclk);
        end
        res_ready = 1'b1;
        @(posedge pclk);
        #1 res_ready = 1'b0;
        @(negedge pclk);
        check("s4_ready_after_hs", {31'b0, op_ready}, 32'd1);
        check("s4_valid_after_hs", {31'b0, res_valid}, 32'd0);
        @(posedge pclk);
        #1 op_valid = 1'b0;
        @(negedge pclk);
        check("s4_accepted", {31'b0, op_ready}, 32'd0);
        wait_res(cyc);
        check("s4_res2", {16'b0, res_data}, 32'h0000_4000);
        take_res();

        // Scenario 5: reset during WR_CMD access
        send_op(8'd9, 8'd9);
        n = 0;
        while (!(psel && penable && pwrite && paddr == 10'h2) && n < 50) begin
            @(negedge pclk);
            n++;
        end
        check("s5_found_cmd_access", {31'b0, n < 50}, 32'd1);
        presetn = 1'b0;
        #1;
        check("s5_psel", {31'b0, psel}, 32'd0);
        check("s5_penable", {31'b0, penable}, 32'd0);
        check("s5_pwrite", {31'b0, pwrite}, 32'd0);
        check("s5_paddr", {22'b0, paddr}, 32'd0);
        check("s5_pwdata", pwdata, 32'd0);
        check("s5_op_ready", {31'b0, op_ready}, 32'd1);
        check("s5_res_valid", {31'b0, res_valid}, 32'd0);
        check("s5_res_data", {16'b0, res_data}, 32'd0);
        check("s5_res_err", {31'b0, res_err}, 32'd0);
        @(negedge pclk);
        presetn = 1'b1;
        send_op(8'd6, 8'd6);
        wait_res(cyc);
        check("s5_res", {16'b0, res_data}, 32'd36);
        take_res();

`ifdef MULT_SEQ_TIMEOUT_EN
        // Scenario 6: slave never completes
        never_done = 1'b1;
        sr = stat_reads;
        send_op(8'd1, 8'd1);
        wait_res(cyc);
        check("s6_polls", stat_reads - sr, 32'd4);
        check("s6_err", {31'b0, res_err}, 32'd1);
        check("s6_res", {16'b0, res_data}, 32'd0);
        take_res();
        never_done = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb2_mult_sequencer.md
# apb2_mult_sequencer

APB2 master that drives the multiplier peripheral from a valid/ready operand stream. Each accepted operand pair is written to the multiplier and multiplicand registers, a start command is written, the command/status register is polled until done, and the 16-bit signed product is read back and presented on a valid/ready result stream. The block sits directly upstream of the multiplier APB slave on a dedicated point-to-point APB2 link with no PREADY and fixed two-cycle transfers.

## Interface
- POLL_LIMIT, 255: maximum status polls per operation before timeout (used only with the timeout feature).
- pclk  in  1  master clock; all logic is clocked on its rising edge.
- presetn  in  1  asynchronous active-low reset.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  sequencer can accept an operand pair.
- op_a  in  8  signed multiplier operand.
- op_b  in  8  signed multiplicand operand.
- res_valid  out  1  product valid.
- res_ready  in  1  consumer accepts the product.
- res_data  out  16  signed product.
- res_err  out  1  product invalid because of timeout (only with the timeout feature, otherwise tied 0).
- psel, penable, pwrite  out  1 each  APB2 control.
- paddr  out  10  word address [11:2].
- pwdata  out  32  write data.
- prdata  in  32  read data; valid only in the access phase of a read.

## Operation
- Address map, word addresses:
  - 0x00: multiplier
  - 0x01: multiplicand
  - 0x02: cmd/status; bit0 = start, bit1 = done
  - 0x03: result, bits [15:0]
- FSM states: IDLE, WR_MER, WR_MCD, WR_CMD, RD_STAT, RD_RES, OUT.
  - Each non-IDLE/OUT state is one APB transfer with a setup cycle (psel=1, penable=0) followed by an access cycle (psel=1, penable=1).
- IDLE:
  - op_ready=1. On op_valid, latch op_a/op_b and go to WR_MER.
- WR_MER:
  - Write op_a, sign-extended to 32 bits, to 0x00.
- WR_MCD:
  - Write op_b, sign-extended to 32 bits, to 0x01.
- WR_CMD:
  - Write 32'h1 to 0x02. This clears a stale done bit and starts the multiply.
- RD_STAT:
  - Read 0x02 and sample prdata in the access cycle.
  - If prdata[1]=1, go to RD_RES. Otherwise repeat RD_STAT back-to-back (a new setup cycle immediately follows the access cycle).
- RD_RES:
  - Read 0x03 and capture prdata[15:0] into res_data in the access cycle.
- OUT:
  - res_valid=1, and res_data is held stable until res_ready. The handshake cycle returns to IDLE.
- Between transfers: psel=0, penable=0; paddr and pwdata hold their last value.
- Latched operands do not change while the sequencer is not in IDLE. op_ready=0 outside IDLE.
- No pipelining: one operation is outstanding at a time.

## Timing
- Reset values:
  - op_ready=1, res_valid=0, res_err=0, res_data=0
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0
  - FSM=IDLE, poll counter=0
- Write data reaches the slave's registers at the end of the setup cycle. The cmd write's setup edge starts the multiply.
- The first RD_STAT setup cycle immediately follows the WR_CMD access cycle.
- Latency from the op handshake to res_valid is at most |op_a| + 16 cycles. The poll phase (which poll access cycle first sees done) adds up to 1 cycle of variation.
- res_valid asserts the cycle after the RD_RES access cycle.
- The op handshake and the result handshake never occur in the same cycle.
- op_valid held with res_ready=1 gives a continuous stream. The next op is accepted the cycle after the result handshake.
- Asynchronous reset mid-transfer:
  - psel drops immediately and the FSM returns to IDLE.
  - The slave is reset by the same presetn, so no stale state remains.

## Configuration
- MULT_SEQ_TIMEOUT_EN defined:
  - An 8-bit poll counter clears on entry to WR_CMD and increments per RD_STAT access.
  - If it reaches POLL_LIMIT without done, skip RD_RES and go to OUT with res_data=16'h0000 and res_err=1.
- MULT_SEQ_TIMEOUT_EN undefined:
  - The sequencer polls indefinitely. There is no counter and res_err is tied 0.

## Structure
- Shared package holds:
  - FSM state enum
  - Register address constants ADDR_MER=10'h00, ADDR_MCD=10'h01, ADDR_CMD=10'h02, ADDR_RES=10'h03
  - CMD_START=32'h1 and STAT_DONE_BIT=1
- One sub-module, apb2_xfer:
  - Single-transfer engine taking req, write, addr, wdata.
  - Drives psel/penable and returns done plus rdata for one cycle.
- The top-level FSM sequences apb2_xfer.

## Test plan
- Bench pairs the sequencer with the multiplier slave.
- Scenario 1: op_a=3, op_b=5 → write order 0x00=3, 0x01=5, 0x02=1; polls; read 0x03; res_data=16'd15; res_valid within 19 cycles.
- Scenario 2: op_a=-4 (8'hFC), op_b=7 → pwdata 0x00=32'hFFFFFFFC; res_data=16'hFFE4 (-28).
- Scenario 3: op_a=0, op_b=-128 → res_data=0 after the minimum number of polls.
- Scenario 4: back-to-back ops (2,2), (-128,-128) with res_ready held low 5 cycles on the first:
  - res_data stays 4 and op_ready stays 0 throughout.
  - Second result = 16'h4000.
- Scenario 5: presetn pulsed low during the WR_CMD access cycle → psel=0 immediately and all outputs at reset values; a subsequent op (6,6) returns 36.
- Scenario 6 (MULT_SEQ_TIMEOUT_EN, POLL_LIMIT=4): slave replaced by a stub that never sets done → exactly 4 status reads, then res_valid=1, res_err=1, res_data=0.
